// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code copy, parallel load and wrap strobe.
// Latency: 1 cycle from inputs to bin/gray/wrap; no backpressure, a step is taken every enabled cycle.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    logic [WIDTH-1:0] next_bin;
    logic             next_wrap;

    always_comb begin
        next_bin  = bin;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_val;
        end else if (en) begin
            if (up) begin
                next_bin  = bin + WIDTH'(1);
                next_wrap = &bin;
            end else begin
                next_bin  = bin - WIDTH'(1);
                next_wrap = ~|bin;
            end
        end
    end

    // Gray is encoded from next_bin so both buses update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= next_bin;
            gray <= next_bin ^ (next_bin >> 1);
            wrap <= next_wrap;
        end
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised synchronous up/down counter that keeps a binary count and a registered Gray-code copy of it.
- Generalises the combinational binary-to-Gray conversion: adds enable, direction control, parallel load and a wrap-around strobe.
- Drives Gray-coded pointers and position codes into clock-domain-crossing logic.
- Both outputs are flop outputs, so the Gray bus is glitch-free.

Parameters:
- WIDTH, 4, counter width in bits (>= 2); count range 0 .. 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- load  input  1  parallel load strobe
- load_val  input  WIDTH  binary value to load
- bin  output  WIDTH  registered binary count
- gray  output  WIDTH  registered Gray code of bin
- wrap  output  1  one-cycle pulse on count wrap-around

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high; it is sampled only at the clock edge.
- Reset, rst=1 at an edge:
  - bin=0, gray=0, wrap=0.
  - Reset overrides load and en.
  - Reset mid-count takes effect at the next edge. No partial state is retained.
- Priority at each edge: rst > load > en > hold.
- Load, load=1:
  - bin <= load_val.
  - gray <= load_val ^ (load_val >> 1).
  - wrap <= 0.
  - en and up are ignored that cycle.
- Count up, en=1, up=1, load=0:
  - bin <= bin + 1, modulo 2^WIDTH.
  - wrap <= 1 only when bin was all-ones, i.e. the transition all-ones -> 0; otherwise wrap <= 0.
- Count down, en=1, up=0, load=0:
  - bin <= bin - 1, modulo 2^WIDTH.
  - wrap <= 1 only when bin was 0, i.e. the transition 0 -> all-ones; otherwise wrap <= 0.
- Hold, en=0, load=0: bin and gray unchanged; wrap <= 0.
- Latency and encoding:
  - bin and gray change in the same cycle; there is no extra pipeline stage between them.
  - gray equals bin ^ (bin >> 1) at every cycle after reset. The MSB of gray equals the MSB of bin.
- Gray property: on every count step (up or down, including wrap), exactly one bit of gray toggles. This is not guaranteed on load.
- wrap: a registered single-cycle pulse. Consecutive wraps with no intervening step are impossible for WIDTH >= 2.
- Arithmetic: unsigned, fixed width; the overflow and underflow carry is dropped.
- Direction reversal is allowed on any cycle and needs no dead cycle. Example: up from 5 then down gives 6 then 5.
- No X propagation from unused inputs: load_val is ignored when load=0; up is ignored when en=0.

Test Plan:
- Reset, WIDTH=4:
  - Drive rst=1 for 2 cycles with en=1 and load=1 -> bin=0000, gray=0000, wrap=0.
- Full up sequence: en=1, up=1 for 16 cycles from 0.
  - gray must run 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - wrap=1 only in the cycle after the 1111->0000 step.
  - Exactly one gray bit changes per step.
- Loads:
  - load=1, load_val=1100 -> next cycle bin=1100, gray=1010, wrap=0.
  - Then load_val=0010 -> bin=0010, gray=0011.
- Down with underflow:
  - From bin=0001, en=1, up=0 for 2 cycles -> bin 0000 (gray 0000), then 1111 (gray 1000) with wrap=1 in that cycle only.
- Priority and hold:
  - load=1 with en=1, up=1, load_val=0111 -> bin=0111, gray=0100; no increment.
  - en=0 for 3 cycles -> bin and gray unchanged, wrap=0.
  - rst=1 asserted mid-count at bin=1010 -> bin=0000, gray=0000 at the next edge.
- Parameter sweep:
  - Run WIDTH=2, 8 and 12 with a random en/up/load stream.
  - Every cycle, check gray == bin ^ (bin >> 1) against a reference model.
  - Check wrap only on the all-ones <-> 0 transitions.
